vga_tile_fill_engine: RTL
=========================

// Module: vga_tile_fill_engine
// PURPOSE
//   Hardware replacement for ROM-sequenced VGA fill programs: paints a full frame of
//   video RAM with a tile pattern, writing one pixel per accepted cycle.
//   Pattern options are solid colour, A/B checkerboard, or checkerboard with one highlight tile.
//   Sits between the control CPU/top-level (start/config) and the VGA video RAM write port.
// PARAMETERS
//   H_RES    256  pixels per row; must be divisible by TILES_X
//   V_RES    256  rows per frame; must be divisible by TILES_Y
//   TILES_X  4    tile columns
//   TILES_Y  4    tile rows
//   COLOR_W  8    colour word width (RRRGGGBB)
// PORTS
//   Clock      in   1          system clock
//   Reset      in   1          asynchronous, active-high reset
//   iStart     in   1          start a frame fill; sampled only in IDLE
//   iAbort     in   1          abandon the fill in progress
//   iMode      in   2          0 solid, 1 checker, 2 checker+highlight, 3 = same as 1
//   iColorA    in   COLOR_W    solid colour / even-parity tile colour
//   iColorB    in   COLOR_W    odd-parity tile colour
//   iColorHi   in   COLOR_W    highlight tile colour (mode 2)
//   iHiTileX   in   clog2(TILES_X)  highlight tile column
//   iHiTileY   in   clog2(TILES_Y)  highlight tile row
//   iWrReady   in   1          RAM accepts the write this cycle
//   oWrEn      out  1          write request valid
//   oWrAddrX   out  clog2(H_RES)  pixel column
//   oWrAddrY   out  clog2(V_RES)  pixel row
//   oWrColor   out  COLOR_W    pixel colour
//   oBusy      out  1          high in RUN
//   oDone      out  1          one-cycle pulse after the last write is accepted
// BEHAVIOUR
//   - Reset: state IDLE; oWrEn=0, oWrAddrX=0, oWrAddrY=0, oWrColor=0, oBusy=0, oDone=0.
//   - FSM IDLE -> RUN on iStart. RUN -> DONE when the last pixel (H_RES-1,V_RES-1) is accepted.
//     DONE -> IDLE after exactly 1 cycle.
//     RUN -> IDLE on iAbort, taking priority over acceptance; no oDone is issued.
//   - On the start cycle, iMode, all colours and the highlight tile are latched.
//     Input changes during RUN have no effect.
//   - iStart asserted in RUN or DONE is ignored.
//     iStart in the same cycle as oDone is ignored; a new fill needs iStart while in IDLE.
//   - Latency: iStart at cycle n gives oWrEn=1 at n+1 with address (0,0).
//   - Handshake: a write is accepted when oWrEn && iWrReady.
//     While oWrEn && !iWrReady, address and colour are held stable.
//     oWrEn stays high for every RUN cycle.
//   - Scan order is raster, X fastest.
//     X wraps H_RES-1 -> 0 and Y increments; Y wraps only at end of frame.
//     Exactly H_RES*V_RES accepts occur per complete fill.
//   - Tile indices tx and ty come from in-tile counters; no divider is used.
//     Tile width is TW = H_RES/TILES_X; tile height is TH = V_RES/TILES_Y.
//     tx increments when the in-tile X count hits TW-1; both counts clear on X wrap.
//     Y is handled the same way.
//   - Colour selection:
//     - mode 0: iColorA;
//     - mode 1/3: (tx+ty)[0] ? iColorB : iColorA;
//     - mode 2: as mode 1, except tile (iHiTileX,iHiTileY) uses iColorHi.
//   - oWrColor is registered alongside its address; it is never one pixel stale.
//   - oBusy = (state==RUN). oDone = (state==DONE).
//   - Reset mid-fill: all outputs return to their reset values immediately (asynchronous).
//   - After abort or done, address outputs return to 0 and oWrEn=0.
// STRUCTURE
//   - Package vga_tile_pkg holds the mode encodings and FSM state constants.
//   - Sub-module tile_axis_counter(RES, TILES) provides a pixel counter, an in-tile counter,
//     a tile index, and wrap/last flags.
//     Two instances are used, X and Y; Y advances on the X wrap.
//   - The top level contains the FSM, config latches and colour mux.
// TESTING
//   1. Default params, mode 1, A=0xFF, B=0xE0, iWrReady=1:
//      65536 writes; (0,0)=FF, (64,0)=E0, (64,64)=FF; oDone is 1 cycle at start+65537.
//   2. Mode 2, Hi=(2,1), Hi colour=0x1C:
//      (128,64)..(191,127) = 1C; (127,64) = FF; all other tiles follow checker.
//   3. iWrReady toggles at random 50%:
//      no address is skipped or repeated; outputs are stable during stalls; 65536 accepts total.
//   4. iAbort at write 1000:
//      oBusy drops the next cycle, no oDone; a following iStart restarts at (0,0).
//   5. iStart pulsed mid-RUN and iColorA changed mid-RUN:
//      no restart; colours match the latched values.
//   6. TILES_X=8, TILES_Y=2, H_RES=V_RES=64, mode 0, Reset asserted mid-fill:
//      outputs are 0 asynchronously; a fresh fill is fully iColorA.

Source files
------------

// File: rtl/vga_tile_pkg.sv
// Shared encodings for the VGA tile fill engine:
// fill modes, FSM states and the checker parity helper.
package vga_tile_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID       = 2'd0,
        MODE_CHECKER     = 2'd1,
        MODE_HILITE      = 2'd2,
        MODE_CHECKER_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Parity of (tx + ty) only depends on the two LSBs.
    function automatic logic checker_odd(
        input logic tx0,
        input logic ty0
    );
        return tx0 ^ ty0;
    endfunction

endpackage

// File: rtl/tile_axis_counter.sv
// One scan axis: pixel position, in-tile counter and tile index.
// Exposes the next tile index so the colour can be registered with its address.
module tile_axis_counter #(
    parameter int RES   = 256,
    parameter int TILES = 4,
    parameter int PW    = $clog2(RES),
    parameter int TIW   = $clog2(TILES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           adv,
    output logic [PW-1:0]  pos,
    output logic [TIW-1:0] tile_nxt,
    output logic           last
);

    localparam int TW = RES / TILES;
    localparam int SW = (TW > 1) ? $clog2(TW) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(RES - 1);
    localparam logic [SW-1:0] SUB_MAX = SW'(TW - 1);

    logic [SW-1:0]  sub;
    logic [SW-1:0]  sub_nxt;
    logic [TIW-1:0] tile;
    logic [PW-1:0]  pos_nxt;

    assign last = (pos == POS_MAX);

    // Next-state: clear, wrap at the end of the axis, or step within/between tiles.
    always_comb begin
        pos_nxt  = pos;
        sub_nxt  = sub;
        tile_nxt = tile;
        if (clr) begin
            pos_nxt  = '0;
            sub_nxt  = '0;
            tile_nxt = '0;
        end else if (adv) begin
            if (last) begin
                pos_nxt  = '0;
                sub_nxt  = '0;
                tile_nxt = '0;
            end else begin
                pos_nxt = pos + 1'b1;
                if (sub == SUB_MAX) begin
                    sub_nxt  = '0;
                    tile_nxt = tile + 1'b1;
                end else begin
                    sub_nxt = sub + 1'b1;
                end
            end
        end
    end

    // Axis state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos  <= '0;
            sub  <= '0;
            tile <= '0;
        end else begin
            pos  <= pos_nxt;
            sub  <= sub_nxt;
            tile <= tile_nxt;
        end
    end

endmodule

// File: rtl/vga_tile_fill_engine.sv
// Frame fill engine: raster-scans video RAM writing one tile-patterned
// pixel per accepted cycle, with abort and a one-cycle done pulse.
module vga_tile_fill_engine
    import vga_tile_pkg::*;
#(
    parameter int H_RES   = 256,
    parameter int V_RES   = 256,
    parameter int TILES_X = 4,
    parameter int TILES_Y = 4,
    parameter int COLOR_W = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iStart,
    input  logic                       iAbort,
    input  logic [1:0]                 iMode,
    input  logic [COLOR_W-1:0]         iColorA,
    input  logic [COLOR_W-1:0]         iColorB,
    input  logic [COLOR_W-1:0]         iColorHi,
    input  logic [$clog2(TILES_X)-1:0] iHiTileX,
    input  logic [$clog2(TILES_Y)-1:0] iHiTileY,
    input  logic                       iWrReady,
    output logic                       oWrEn,
    output logic [$clog2(H_RES)-1:0]   oWrAddrX,
    output logic [$clog2(V_RES)-1:0]   oWrAddrY,
    output logic [COLOR_W-1:0]         oWrColor,
    output logic                       oBusy,
    output logic                       oDone
);

    localparam int XW  = $clog2(H_RES);
    localparam int YW  = $clog2(V_RES);
    localparam int TXW = $clog2(TILES_X);
    localparam int TYW = $clog2(TILES_Y);

    state_e               state;
    mode_e                mode_q;
    logic [COLOR_W-1:0]   col_a_q;
    logic [COLOR_W-1:0]   col_b_q;
    logic [COLOR_W-1:0]   col_hi_q;
    logic [TXW-1:0]       hi_x_q;
    logic [TYW-1:0]       hi_y_q;

    logic [XW-1:0]        x_pos;
    logic [YW-1:0]        y_pos;
    logic [TXW-1:0]       x_tile_nxt;
    logic [TYW-1:0]       y_tile_nxt;
    logic                 x_last;
    logic                 y_last;

    logic                 run;
    logic                 accept;
    logic                 abort_now;
    logic                 adv_x;
    logic                 adv_y;
    logic                 frame_last;

    assign run        = (state == ST_RUN);
    assign accept     = run & oWrEn & iWrReady;
    assign abort_now  = run & iAbort;
    assign adv_x      = accept & ~iAbort;
    assign adv_y      = adv_x & x_last;
    assign frame_last = x_last & y_last;

    assign oWrAddrX = x_pos;
    assign oWrAddrY = y_pos;

    tile_axis_counter #(
        .RES   (H_RES),
        .TILES (TILES_X)
    ) u_x (
        .clk      (Clock),
        .rst      (Reset),
        .clr      (abort_now),
        .adv      (adv_x),
        .pos      (x_pos),
        .tile_nxt (x_tile_nxt),
        .last     (x_last)
    );

    tile_axis_counter #(
        .RES   (V_RES),
        .TILES (TILES_Y)
    ) u_y (
        .clk      (Clock),
        .rst      (Reset),
        .clr      (abort_now),
        .adv      (adv_y),
        .pos      (y_pos),
        .tile_nxt (y_tile_nxt),
        .last     (y_last)
    );

    function automatic logic [COLOR_W-1:0] pick(
        input mode_e              m,
        input logic [COLOR_W-1:0] a,
        input logic [COLOR_W-1:0] b,
        input logic [COLOR_W-1:0] h,
        input logic [TXW-1:0]     hx,
        input logic [TYW-1:0]     hy,
        input logic [TXW-1:0]     tx,
        input logic [TYW-1:0]     ty
    );
        logic odd;
        logic hit;
        logic [COLOR_W-1:0] c;
        odd = checker_odd(tx[0], ty[0]);
        hit = (tx == hx) && (ty == hy);
        c   = a;
        unique case (m)
            MODE_SOLID:       c = a;
            MODE_CHECKER:     c = odd ? b : a;
            MODE_CHECKER_ALT: c = odd ? b : a;
            MODE_HILITE:      c = hit ? h : (odd ? b : a);
            default:          c = a;
        endcase
        return c;
    endfunction

    // Control FSM with config latches and registered write outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_SOLID;
            col_a_q  <= '0;
            col_b_q  <= '0;
            col_hi_q <= '0;
            hi_x_q   <= '0;
            hi_y_q   <= '0;
            oWrEn    <= 1'b0;
            oWrColor <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        state    <= ST_RUN;
                        mode_q   <= mode_e'(iMode);
                        col_a_q  <= iColorA;
                        col_b_q  <= iColorB;
                        col_hi_q <= iColorHi;
                        hi_x_q   <= iHiTileX;
                        hi_y_q   <= iHiTileY;
                        oWrEn    <= 1'b1;
                        oBusy    <= 1'b1;
                        oWrColor <= pick(mode_e'(iMode), iColorA,
                                         iColorB, iColorHi,
                                         iHiTileX, iHiTileY,
                                         '0, '0);
                    end
                end
                ST_RUN: begin
                    if (iAbort) begin
                        state    <= ST_IDLE;
                        oWrEn    <= 1'b0;
                        oBusy    <= 1'b0;
                        oWrColor <= '0;
                    end else if (oWrEn && iWrReady) begin
                        if (frame_last) begin
                            state    <= ST_DONE;
                            oWrEn    <= 1'b0;
                            oBusy    <= 1'b0;
                            oDone    <= 1'b1;
                            oWrColor <= '0;
                        end else begin
                            oWrColor <= pick(mode_q, col_a_q,
                                             col_b_q, col_hi_q,
                                             hi_x_q, hi_y_q,
                                             x_tile_nxt, y_tile_nxt);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    oDone <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    oWrEn <= 1'b0;
                    oBusy <= 1'b0;
                    oDone <= 1'b0;
                end
            endcase
        end
    end

endmodule
